// File: rtl/sanduba_dispense_arbiter.sv
// Round-robin share of one sandwich dispenser among N_REQ front-ends, with per-item stock and a delivery timeout.
// Latency: req -> gnt 1 cycle, -> disp_start 2 cycles, done/fail within 4+TTD of grant; req is a held level, no backpressure beyond gnt.
module sanduba_dispense_arbiter #(
  parameter int N_REQ      = 2,
  parameter int TTD        = 10,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] item,
  input  logic               disp_ack,
  input  logic               reload,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   fail,
  output logic               disp_start,
  output logic [1:0]         disp_item,
  output logic               busy,
  output logic [2:0]         stock_empty
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = (TTD > 1) ? $clog2(TTD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FIRE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, w_q, win, cand;
  logic                 win_vld;
  logic [1:0]           item_q;
  logic [TW-1:0]        timer_q;
  logic                 ok_q, ok_d;
  logic [STOCK_W-1:0]   stock_q [3];
  logic [STOCK_W-1:0]   stock_sel;
  logic [N_REQ-1:0]     w_oh;
  logic                 timeout;

  // First requester at or above ptr, wrapping around.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    stock_sel = '0;
    for (int k = 0; k < 3; k++) begin
      if (item_q == 2'(k + 1)) stock_sel = stock_q[k];
    end
  end

  assign timeout = (timer_q == TW'(TTD - 1));

  always_comb begin
    state_d = state_q;
    ok_d    = ok_q;
    case (state_q)
      S_IDLE:  if (win_vld) state_d = S_CHECK;
      S_CHECK: begin
        if (item_q == 2'b00 || stock_sel == '0) begin
          ok_d    = 1'b0;
          state_d = S_RESP;
        end else begin
          state_d = S_FIRE;
        end
      end
      S_FIRE:  state_d = S_WAIT;
      S_WAIT: begin
        if (disp_ack) begin
          ok_d    = 1'b1;
          state_d = S_RESP;
        end else if (timeout) begin
          ok_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      w_q     <= '0;
      item_q  <= 2'b00;
      timer_q <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ok_q    <= ok_d;
      if (state_q == S_IDLE && win_vld) begin
        w_q    <= win;
        item_q <= item[{win, 1'b0} +: 2];
      end
      if (state_q == S_FIRE) begin
        timer_q <= '0;
      end else if (state_q == S_WAIT && !disp_ack && !timeout) begin
        timer_q <= timer_q + 1'b1;
      end
      if (state_q == S_RESP) begin
        ptr_q <= (w_q == IW'(N_REQ - 1)) ? '0 : w_q + 1'b1;
      end
    end
  end

  // Reload overrides a same-cycle decrement; CHECK guarantees stock > 0 here.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (reset || reload) begin
        stock_q[k] <= STOCK_W'(STOCK_INIT);
      end else if (state_q == S_WAIT && disp_ack && item_q == 2'(k + 1)) begin
        stock_q[k] <= stock_q[k] - 1'b1;
      end
    end
  end

  assign w_oh       = N_REQ'(1) << w_q;
  assign busy       = (state_q != S_IDLE);
  assign gnt        = busy ? w_oh : '0;
  assign done       = (state_q == S_RESP && ok_q) ? w_oh : '0;
  assign fail       = (state_q == S_RESP && !ok_q) ? w_oh : '0;
  assign disp_start = (state_q == S_FIRE);
  assign disp_item  = item_q;

  always_comb begin
    for (int k = 0; k < 3; k++) stock_empty[k] = (stock_q[k] == '0);
  end

endmodule

// File: tb/tb_sanduba_dispense_arbiter.sv
// Randomized and directed bench: a transaction-age reference model is checked every cycle, plus literal pins.
module tb_sanduba_dispense_arbiter;

  localparam int N    = 2;
  localparam int TTD  = 10;
  localparam int SINIT = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] item = '0;
  logic         disp_ack = 1'b0;
  logic         reload = 1'b0;
  logic [N-1:0] gnt, done, fail;
  logic         disp_start, busy;
  logic [1:0]   disp_item;
  logic [2:0]   stock_empty;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  sanduba_dispense_arbiter #(.N_REQ(N), .TTD(TTD), .STOCK_W(4), .STOCK_INIT(SINIT)) dut (
    .clock(clock), .reset(reset), .req(req), .item(item), .disp_ack(disp_ack),
    .reload(reload), .gnt(gnt), .done(done), .fail(fail), .disp_start(disp_start),
    .disp_item(disp_item), .busy(busy), .stock_empty(stock_empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is tracked by its age in cycles since grant (age 1 = grant cycle).
  bit m_active = 1'b0;
  int m_age = 0, m_w = 0, m_item = 0, m_resp = 1000, m_ptr = 0;
  bit m_good = 1'b0, m_ok = 1'b0;
  int m_stock [4] = '{0, SINIT, SINIT, SINIT};

  always @(negedge clock) begin
    logic [N-1:0] e_oh, e_gnt, e_done, e_fail;
    logic         e_start, e_resp;
    int           nst [4];
    bit           found;
    int           idx;
    e_oh    = N'(1) << m_w;
    e_gnt   = m_active ? e_oh : '0;
    e_start = m_active && m_good && m_age == 2;
    e_resp  = m_active && m_age == m_resp;
    e_done  = (e_resp && m_ok) ? e_oh : '0;
    e_fail  = (e_resp && !m_ok) ? e_oh : '0;
    if (chk_en) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(e_done));
      chk("fail", 32'(fail), 32'(e_fail));
      chk("disp_start", 32'(disp_start), 32'(e_start));
      chk("stock_empty", 32'(stock_empty),
          32'({m_stock[3] == 0, m_stock[2] == 0, m_stock[1] == 0}));
      if (m_active && m_good && m_age >= 2 && m_age < m_resp)
        chk("disp_item", 32'(disp_item), 32'(m_item));
    end
    if (reset) begin
      m_active = 1'b0;
      m_ptr    = 0;
      m_good   = 1'b0;
      for (int k = 1; k < 4; k++) m_stock[k] = SINIT;
    end else begin
      for (int k = 0; k < 4; k++) nst[k] = m_stock[k];
      if (!m_active) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          idx = (m_ptr + i) % N;
          if (!found && req[idx]) begin
            found  = 1'b1;
            m_w    = idx;
            m_item = int'(item[2*idx +: 2]);
          end
        end
        if (found) begin
          m_active = 1'b1;
          m_age    = 1;
          m_resp   = 1000;
          m_good   = 1'b0;
          m_ok     = 1'b0;
        end
      end else begin
        if (m_age == 1) begin
          m_good = (m_item != 0) && (m_stock[m_item] > 0);
          if (!m_good) m_resp = 2;
        end else if (m_good && m_age >= 3 && m_resp == 1000) begin
          if (disp_ack) begin
            m_ok   = 1'b1;
            m_resp = m_age + 1;
            nst[m_item] = nst[m_item] - 1;
          end else if (m_age == TTD + 2) begin
            m_ok   = 1'b0;
            m_resp = m_age + 1;
          end
        end
        if (m_age == m_resp) begin
          m_active = 1'b0;
          m_ptr    = (m_w + 1) % N;
        end else begin
          m_age++;
        end
      end
      if (reload) for (int k = 1; k < 4; k++) nst[k] = SINIT;
      for (int k = 0; k < 4; k++) m_stock[k] = nst[k];
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Runs one transaction with req/item already driven; ack comes d cycles after disp_start (d<=0: never).
  task automatic txn(input int d, output logic [N-1:0] g, output int gcnt, output bit fired,
                     output int since, output logic [N-1:0] rd, output logic [N-1:0] rf);
    int cnt;
    gcnt = 0;
    while (gnt == '0 && gcnt < 20) begin
      cyc();
      gcnt++;
    end
    if (gnt == '0) chk("grant_timeout", 32'(gcnt), 32'd0);
    g = gnt;
    fired = 1'b0;
    since = -1;
    cnt = 0;
    while (cnt < 40) begin
      if (disp_start) begin
        fired = 1'b1;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      disp_ack = (d > 0 && since == d);
      if (done != '0 || fail != '0) break;
      cyc();
      cnt++;
    end
    if (cnt >= 40) chk("resp_timeout", 32'(cnt), 32'd0);
    rd = done;
    rf = fail;
    disp_ack = 1'b0;
    cyc();
  endtask

  initial begin
    logic [N-1:0] g, rd, rf;
    int gcnt, since;
    bit fired;
    logic [N-1:0] rr_exp [4];
    rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

    cyc();
    chk_en = 1'b1;
    cyc();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stock_empty", 32'(stock_empty), 32'd0);
    reset = 1'b0;

    // Single green request: grant +1, fire +2, ack +3, done +4.
    req = 2'b01; item = 4'b0001;
    txn(1, g, gcnt, fired, since, rd, rf);
    req = '0;
    chk("single_gnt", 32'(g), 32'd1);
    chk("single_gnt_lat", 32'(gcnt), 32'd1);
    chk("single_done_lat", 32'(since), 32'd2);
    chk("single_done", 32'(rd), 32'd1);
    chk("single_green_stock", 32'(m_stock[1]), 32'd7);

    // Round robin with atum; ptr is 1 after the single transaction.
    req = 2'b11; item = 4'b1010;
    for (int t = 0; t < 4; t++) begin
      txn(1, g, gcnt, fired, since, rd, rf);
      chk("rr_gnt", 32'(g), 32'(rr_exp[t]));
      chk("rr_done", 32'(rd), 32'(rr_exp[t]));
    end
    req = '0;

    // Timeout with bacon.
    req = 2'b01; item = 4'b0011;
    txn(0, g, gcnt, fired, since, rd, rf);
    req = '0;
    chk("timeout_fail", 32'(rf), 32'd1);
    chk("timeout_lat", 32'(since), 32'(TTD + 1));
    chk("timeout_bacon_stock", 32'(m_stock[3]), 32'd8);

    // item 00 fails without firing.
    req = 2'b10; item = 4'b0011;
    txn(1, g, gcnt, fired, since, rd, rf);
    req = '0;
    chk("none_fail", 32'(rf), 32'd2);
    chk("none_fired", 32'(fired), 32'd0);

    // Ack on the timeout cycle wins.
    req = 2'b01; item = 4'b0010;
    txn(TTD, g, gcnt, fired, since, rd, rf);
    req = '0;
    chk("ack_timeout_done", 32'(rd), 32'd1);

    // Stock out on green.
    reload = 1'b1; cyc(); reload = 1'b0;
    req = 2'b01; item = 4'b0001;
    for (int t = 0; t < 8; t++) begin
      txn(1, g, gcnt, fired, since, rd, rf);
      req = '0; cyc(); req = 2'b01;
    end
    chk("green_empty", 32'(stock_empty[0]), 32'd1);
    txn(1, g, gcnt, fired, since, rd, rf);
    req = '0;
    chk("stockout_fail", 32'(rf), 32'd1);
    chk("stockout_fired", 32'(fired), 32'd0);
    reload = 1'b1; cyc(); reload = 1'b0;
    chk("reload_empty", 32'(stock_empty), 32'd0);
    chk("reload_green_stock", 32'(m_stock[1]), 32'd8);

    // Reset during WAIT aborts silently.
    req = 2'b01; item = 4'b0010;
    for (int t = 0; t < 10 && !disp_start; t++) cyc();
    cyc();
    reset = 1'b1; req = '0;
    cyc();
    reset = 1'b0;
    chk("rst_wait_gnt", 32'(gnt), 32'd0);
    chk("rst_wait_busy", 32'(busy), 32'd0);
    chk("rst_wait_resp", 32'({done, fail}), 32'd0);

    // Random traffic against the model.
    for (int t = 0; t < 600; t++) begin
      reset    = ($urandom_range(199) == 0);
      req      = N'($urandom);
      item     = (2 * N)'($urandom);
      disp_ack = ($urandom_range(3) == 0);
      reload   = ($urandom_range(39) == 0);
      cyc();
    end
    reset = 1'b0; req = '0; disp_ack = 1'b0; reload = 1'b0;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
